// File: rtl/btn_seq_pkg.sv
// Shared types and PIO register map for the button event sequencer.
package btn_seq_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    CAP,
    CLR,
    PUSH,
    HOLD
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EVT_W = 4;

endpackage

// File: rtl/btn_evt_fifo.sv
// First-word fall-through event queue; a push into a full queue succeeds only
// when the head pops on the same clock, otherwise it is dropped and flagged.
module btn_evt_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [4:0]       count_o,
  output logic             drop_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             full, pop, push_ok;

  assign full    = (count_q == 5'(FIFO_DEPTH));
  assign pop     = (count_q != 5'd0) && pop_ready_i;
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign count_d  = count_q + 5'(push_ok) - 5'(pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != 5'd0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/btn_event_sequencer.sv
// Services button-PIO interrupts: reads and clears the edge-capture register,
// then queues each nonzero button mask for a downstream consumer.
module btn_event_sequencer
  import btn_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  MASK_INIT  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pio_irq,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        evt_valid,
  output logic [3:0]  evt_data,
  input  logic        evt_ready,
  output logic [4:0]  evt_count,
  output logic        overflow,
  input  logic        ovf_clr
);

  state_e           state_q, state_d;
  logic [EVT_W-1:0] cap_mask_q, cap_mask_d;
  logic             overflow_q, overflow_d;
  logic             push;
  logic             drop;
  logic             unused_rdata;

  assign unused_rdata = ^avm_readdata[31:EVT_W];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    cap_mask_d     = cap_mask_q;
    push           = 1'b0;
    avm_address    = ADDR_DATA;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = '0;
    unique case (state_q)
      INIT: begin
        avm_address    = ADDR_MASK;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = {28'b0, MASK_INIT};
        state_d        = IDLE;
      end
      IDLE: begin
        if (pio_irq && en) state_d = RD;
      end
      RD: begin
        avm_address    = ADDR_EDGE;
        avm_chipselect = 1'b1;
        state_d        = CAP;
      end
      CAP: begin
        // The PIO answers one cycle after the RD address, so data lands here.
        avm_address    = ADDR_EDGE;
        avm_chipselect = 1'b1;
        cap_mask_d     = avm_readdata[EVT_W-1:0];
        state_d        = CLR;
      end
      CLR: begin
        avm_address    = ADDR_EDGE;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = {28'b0, cap_mask_q};
        state_d        = PUSH;
      end
      PUSH: begin
        push    = (cap_mask_q != '0);
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // A drop in the same cycle as a clear request must still be reported.
  assign overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      cap_mask_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_mask_q <= cap_mask_d;
      overflow_q <= overflow_d;
    end
  end

  btn_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (EVT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (cap_mask_q),
    .pop_ready_i (evt_ready),
    .valid_o     (evt_valid),
    .data_o      (evt_data),
    .count_o     (evt_count),
    .drop_o      (drop)
  );

  assign overflow = overflow_q;

endmodule

// File: doc/btn_event_sequencer.md
BTN_EVENT_SEQUENCER -- requirements
Module: btn_event_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event queue depth in entries (power of two, 2..16).
REQ-002 Parameter MASK_INIT, default 4'hF, irq_mask value written to the button PIO after reset.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  1 = service PIO interrupts; 0 = stay idle once any in-progress service sequence ends.
REQ-006 pio_irq  input  1  interrupt from the button PIO.
REQ-007 avm_address  output  2  PIO register address.
REQ-008 avm_chipselect  output  1  PIO select.
REQ-009 avm_write_n  output  1  active-low write strobe.
REQ-010 avm_writedata  output  32  PIO write data.
REQ-011 avm_readdata  input  32  PIO read data, registered in the PIO with 1-cycle latency, address-driven.
REQ-012 evt_valid  output  1  event queue non-empty.
REQ-013 evt_data  output  4  button mask at the queue head.
REQ-014 evt_ready  input  1  consumer accepts the head event.
REQ-015 evt_count  output  5  queue occupancy, 0..FIFO_DEPTH.
REQ-016 overflow  output  1  sticky flag: an event was dropped because the queue was full.
REQ-017 ovf_clr  input  1  clears overflow.

Function
REQ-018 FSM states SHALL be INIT, IDLE, RD, CAP, CLR, PUSH, HOLD.
REQ-019 INIT: for exactly one cycle, drive address=2, chipselect=1, write_n=0, writedata={28'b0,MASK_INIT}, then go to IDLE.
REQ-020 IDLE: if pio_irq=1 and en=1, go to RD; otherwise remain in IDLE.
REQ-021 RD: drive address=3, chipselect=1, write_n=1 for one cycle, then go to CAP.
REQ-022 CAP: hold address=3; at the end of the cycle, latch avm_readdata[3:0] into cap_mask; go to CLR.
REQ-023 CLR: drive address=3, chipselect=1, write_n=0, writedata={28'b0,cap_mask} for one cycle; go to PUSH.
REQ-024 PUSH: push cap_mask if it is nonzero; if the queue is full and no pop occurs in the same cycle, drop it and set overflow; cap_mask=0 pushes nothing; go to HOLD.
REQ-025 HOLD: one guard cycle so pio_irq can fall, then go to IDLE; a total of 5 cycles from RD to IDLE.
REQ-026 Outside INIT/RD/CAP/CLR, drive address=0, chipselect=0, write_n=1, writedata=0.
REQ-027 en=0 SHALL NOT abort a sequence in progress; it only blocks the IDLE->RD transition.
REQ-028 Queue is first-word fall-through: evt_valid = (evt_count!=0), evt_data = head entry, and the head pops on the clock where evt_valid & evt_ready.
REQ-029 Push and pop in the same cycle, including when the queue is full: both take effect and evt_count is unchanged.
REQ-030 Pointers wrap modulo FIFO_DEPTH; evt_count never exceeds FIFO_DEPTH or underflows.
REQ-031 If ovf_clr and an overflow drop occur in the same cycle, set wins.
REQ-032 An edge that the PIO captures in the CLR cycle is lost; this is an accepted limitation and does not set overflow.

Reset
REQ-033 reset=1 SHALL force the INIT state, cap_mask=0, empty queue, evt_count=0, evt_valid=0, evt_data=0, and overflow=0.
REQ-034 Reset asserted mid-sequence SHALL abandon that sequence; the mask write is then re-issued in INIT.

Structure
REQ-035 Shared package btn_seq_pkg holds the state enum and the PIO address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
REQ-036 The queue SHALL be sub-module btn_evt_fifo, with parameters FIFO_DEPTH and width 4, and synchronous active-high reset.

Verification
REQ-037 Release reset -> the first cycle is a write to address 2 with data 0xF, then the FSM reaches IDLE.
REQ-038 With a PIO model, pulse button 1 low -> read of address 3, write of address 3, evt_data=4'h2, evt_valid=1, evt_count=1.
REQ-039 Five presses with evt_ready=0 and FIFO_DEPTH=4 -> evt_count=4, overflow=1; then ovf_clr -> overflow=0.
REQ-040 Full queue with evt_ready=1 during PUSH -> evt_count stays 4, no overflow, and data stays in order.
REQ-041 en=0 with pio_irq high -> no bus activity; raise en -> service begins in the next cycle.
REQ-042 Assert reset during CLR -> all outputs return to reset values and the INIT mask write repeats.
